ring_cadence_ctrl: RTL and testbench
====================================

# ring_cadence_ctrl

Sequencing controller for the phone alert path: turns an incoming-call level into a timed ring cadence and steers it to the loudspeaker ringer or the vibration motor according to `vibrate_mode`. It sits directly in front of the ringer/motor drive outputs and replaces a static "ring while call present" gating with bursts, answer handling and missed-call detection.

## Interface
- `ON_CYCLES`, 4, cycles per burst with alert active (≥1)
- `OFF_CYCLES`, 2, silent cycles after each burst (≥1)
- `MAX_BURSTS`, 3, bursts before an unanswered call is declared missed (≥1)
- `CNT_W`, 8, width of missed-call counter
- `clk`  in  1  sole clock, rising edge
- `areset_n`  in  1  asynchronous, active-low reset
- `call`  in  1  incoming call present (level)
- `answer`  in  1  user answered (sampled each edge)
- `vibrate_mode`  in  1  1 = motor, 0 = ringer
- `ringer`  out  1  loudspeaker drive, registered
- `motor`  out  1  vibration drive, registered
- `busy`  out  1  FSM not in IDLE, registered
- `missed`  out  1  one-cycle pulse on missed call
- `missed_count`  out  CNT_W  saturating missed-call count

## Operation
- States: IDLE, ON, OFF, MISSED. Registered `call_q` for edge detect.
- IDLE → ON on `call & ~call_q & ~answer`; timer = ON_CYCLES-1, burst = 0. Call held high never re-triggers.
- ON: timer decrements; at 0 → OFF, timer = OFF_CYCLES-1, burst += 1.
- OFF: at timer 0 → MISSED if burst == MAX_BURSTS, else ON with timer = ON_CYCLES-1.
- ON/OFF with `answer` = 1 → IDLE; no missed pulse. Answer has priority over every other event, including simultaneous call drop and timer expiry.
- ON/OFF with `call` = 0 and `answer` = 0 → MISSED (caller hung up).
- MISSED: one cycle; `missed` = 1; `missed_count` += 1, saturating at 2^CNT_W-1; → IDLE unconditionally.
- Output decode: `ringer` <= (next_state==ON) & ~vibrate_mode; `motor` <= (next_state==ON) & vibrate_mode; never both 1.
- `vibrate_mode` is live. A change mid-burst swaps the drive at the next edge and does not restart the timer.
- Burst counter width is clog2(MAX_BURSTS+1). Timer width is clog2(max(ON_CYCLES, OFF_CYCLES)).

## Timing
- Reset (async assert, sync deassert assumed upstream): state IDLE, timer 0, burst 0, `call_q` 0. `ringer`, `motor`, `busy`, `missed` = 0. `missed_count` = 0.
- Call rising at edge t → `ringer`/`motor` high after edge t, for exactly ON_CYCLES cycles, then low for OFF_CYCLES cycles.
- Unanswered call: `missed` pulses in cycle MAX_BURSTS×(ON_CYCLES+OFF_CYCLES) after the first alert cycle. `missed_count` updates in that same cycle.
- `answer` or call drop sampled at edge e → outputs 0 after edge e.
- Reset mid-operation aborts immediately with no missed pulse.

## Configuration
- `RING_CADENCE_MISSED_CNT_EN` defined: `missed_count` register and saturating increment are present as described.
- Not defined: no counter logic; `missed_count` is tied to 0. The `missed` pulse and the FSM are unchanged.

## Structure
- Shared package `ring_pkg`: state enum typedef (IDLE, ON, OFF, MISSED) and default cadence constants.
- One sub-module, `cadence_timer`: a loadable down-counter with a `zero` flag, instantiated once for ON/OFF timing.

## Test plan
- Defaults, call rises and is held, `vibrate_mode` = 0, no answer → `ringer` pattern 4 high / 2 low ×3; `motor` stays 0; `missed` pulses once at alert cycle 18; count = 1; no re-ring while call stays high.
- Same stimulus with `vibrate_mode` = 1 → identical pattern on `motor`, `ringer` stays 0. Toggle `vibrate_mode` mid-burst → drive swaps next cycle and burst length stays 4.
- `answer` pulse in the 2nd cycle of burst 2 → outputs 0 next cycle, `busy` = 0, no `missed`, count unchanged.
- Call drops during OFF of burst 1 → `missed` the next cycle, count +1. Call drop together with `answer` → no `missed`.
- `areset_n` low mid-ON → `ringer`, `busy`, and count go to 0 without waiting for a clock edge.
- `CNT_W` = 2, five missed calls → count 1, 2, 3, 3, 3. Without the macro → count stays 0 and `missed` still pulses.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared state encoding and default cadence for the ring cadence controller.
package ring_pkg;
  typedef enum logic [1:0] {IDLE, ON, OFF, MISSED} ring_state_e;

  localparam int RING_ON_DEF     = 4;
  localparam int RING_OFF_DEF    = 2;
  localparam int RING_BURSTS_DEF = 3;
  localparam int RING_CNT_W_DEF  = 8;
endpackage

// File: rtl/cadence_timer.sv
// Loadable down-counter; holds at zero and flags it.
module cadence_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         areset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n)                cnt_q <= '0;
    else if (load)                cnt_q <= load_val;
    else if (dec && cnt_q != '0)  cnt_q <= cnt_q - 1'b1;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/ring_cadence_ctrl.sv
// Ring cadence controller: bursts the alert onto ringer or motor, detects missed calls.
// Missed-call counter is built only when RING_CADENCE_MISSED_CNT_EN is defined.
module ring_cadence_ctrl
  import ring_pkg::*;
#(
  parameter int ON_CYCLES  = RING_ON_DEF,
  parameter int OFF_CYCLES = RING_OFF_DEF,
  parameter int MAX_BURSTS = RING_BURSTS_DEF,
  parameter int CNT_W      = RING_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             call,
  input  logic             answer,
  input  logic             vibrate_mode,
  output logic             ringer,
  output logic             motor,
  output logic             busy,
  output logic             missed,
  output logic [CNT_W-1:0] missed_count
);
  localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int BW   = $clog2(MAX_BURSTS + 1);

  ring_state_e   state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          call_q;
  logic          ringer_q, motor_q, busy_q, missed_q;
  logic          t_load, t_dec, t_zero;
  logic [TW-1:0] t_val;

  cadence_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .areset_n (areset_n),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  // Answer outranks hang-up, which outranks timer expiry.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    t_load  = 1'b0;
    t_val   = '0;
    unique case (state_q)
      IDLE: if (call && !call_q && !answer) begin
        state_d = ON;
        t_load  = 1'b1;
        t_val   = TW'(ON_CYCLES - 1);
        burst_d = '0;
      end
      ON: begin
        if (answer)     state_d = IDLE;
        else if (!call) state_d = MISSED;
        else if (t_zero) begin
          state_d = OFF;
          t_load  = 1'b1;
          t_val   = TW'(OFF_CYCLES - 1);
          burst_d = burst_q + 1'b1;
        end
      end
      OFF: begin
        if (answer)     state_d = IDLE;
        else if (!call) state_d = MISSED;
        else if (t_zero) begin
          if (burst_q == BW'(MAX_BURSTS)) state_d = MISSED;
          else begin
            state_d = ON;
            t_load  = 1'b1;
            t_val   = TW'(ON_CYCLES - 1);
          end
        end
      end
      MISSED:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    t_dec = (state_q == ON || state_q == OFF) && !t_load;
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q  <= IDLE;
      burst_q  <= '0;
      call_q   <= 1'b0;
      ringer_q <= 1'b0;
      motor_q  <= 1'b0;
      busy_q   <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      call_q   <= call;
      ringer_q <= (state_d == ON) && !vibrate_mode;
      motor_q  <= (state_d == ON) &&  vibrate_mode;
      busy_q   <= (state_d != IDLE);
      missed_q <= (state_d == MISSED);
    end
  end

  assign ringer = ringer_q;
  assign motor  = motor_q;
  assign busy   = busy_q;
  assign missed = missed_q;

`ifdef RING_CADENCE_MISSED_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n)                               cnt_q <= '0;
    else if (state_d == MISSED && cnt_q != '1)   cnt_q <= cnt_q + 1'b1;
  end

  assign missed_count = cnt_q;
`else
  assign missed_count = '0;
`endif
endmodule

// File: tb/tb_ring_cadence_ctrl.sv
// Random + directed bench for ring_cadence_ctrl against a phase-count reference model.
module tb_ring_cadence_ctrl;
  localparam int ON_C  = 4;
  localparam int OFF_C = 2;
  localparam int MAXB  = 3;
  localparam int P     = ON_C + OFF_C;
  localparam int LEN   = MAXB * P;

  logic       clk = 1'b0;
  logic       areset_n = 1'b0;
  logic       call = 1'b0, answer = 1'b0, vib = 1'b0;
  logic       ringer, motor, busy, missed;
  logic [7:0] cnt8;
  logic       ringer2, motor2, busy2, missed2;
  logic [1:0] cnt2;

  int n_chk = 0, n_fail = 0;

  // model: active flag plus cycles elapsed since first alert cycle
  logic m_act = 1'b0;
  int   m_k = 0;
  logic m_cprev = 1'b0;
  int   m_cnt8 = 0, m_cnt2 = 0;

  always #5 clk = ~clk;

  ring_cadence_ctrl #(.ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C), .MAX_BURSTS(MAXB), .CNT_W(8)) dut (
    .clk(clk), .areset_n(areset_n), .call(call), .answer(answer), .vibrate_mode(vib),
    .ringer(ringer), .motor(motor), .busy(busy), .missed(missed), .missed_count(cnt8)
  );

  ring_cadence_ctrl #(.ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C), .MAX_BURSTS(MAXB), .CNT_W(2)) dut2 (
    .clk(clk), .areset_n(areset_n), .call(call), .answer(answer), .vibrate_mode(vib),
    .ringer(ringer2), .motor(motor2), .busy(busy2), .missed(missed2), .missed_count(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 1'b0; m_k = 0; m_cprev = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
  endtask

  task automatic model_edge(input logic c, input logic a);
    if (m_act) begin
      if (m_k == LEN)                 m_act = 1'b0;
      else if (a)                     m_act = 1'b0;
      else if (!c || m_k + 1 == LEN) begin
        m_k = LEN;
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3)   m_cnt2++;
      end else                        m_k++;
    end else if (c && !m_cprev && !a) begin
      m_act = 1'b1;
      m_k   = 0;
    end
    m_cprev = c;
  endtask

  task automatic check_all();
    logic alert, e_miss;
    int   e8, e2;
    alert  = m_act && m_k < LEN && (m_k % P) < ON_C;
    e_miss = m_act && m_k == LEN;
`ifdef RING_CADENCE_MISSED_CNT_EN
    e8 = m_cnt8; e2 = m_cnt2;
`else
    e8 = 0; e2 = 0;
`endif
    chk("ringer", ringer, alert && !vib);
    chk("motor",  motor,  alert &&  vib);
    chk("busy",   busy,   m_act);
    chk("missed", missed, e_miss);
    chk("count8", cnt8,   e8);
    chk("ringer_w2", ringer2, alert && !vib);
    chk("missed_w2", missed2, e_miss);
    chk("count2", cnt2,   e2);
  endtask

  task automatic step(input logic c, input logic a, input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      call = c; answer = a; vib = v;
      @(posedge clk);
      model_edge(c, a);
      #1 check_all();
    end
  endtask

  initial begin
    model_reset();
    #3 check_all();
    @(negedge clk) areset_n = 1'b1;
    step(0, 0, 0, 2);

    // full unanswered call on ringer, held high afterwards
    step(1, 0, 0, 26);
    step(0, 0, 0, 2);
    // motor, with a vibrate toggle mid-burst
    step(1, 0, 1, 2);
    step(1, 0, 0, 1);
    step(1, 0, 1, 22);
    step(0, 0, 1, 2);
    // answer in 2nd cycle of burst 2
    step(1, 0, 0, 7);
    step(1, 1, 0, 1);
    step(1, 0, 0, 4);
    step(0, 0, 0, 2);
    // hang-up during OFF of burst 1
    step(1, 0, 0, 5);
    step(0, 0, 0, 3);
    // hang-up together with answer
    step(1, 0, 0, 3);
    step(0, 1, 0, 1);
    step(0, 0, 0, 3);

    // async reset mid-ON
    step(1, 0, 0, 2);
    #2 areset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_ringer", ringer, 1'b0);
    chk("rst_busy",   busy,   1'b0);
    chk("rst_count",  cnt8,   8'd0);
    @(negedge clk);
    call = 1'b0; answer = 1'b0; areset_n = 1'b1;
    step(0, 0, 0, 2);

    // five hang-up misses to walk the narrow counter into saturation
    for (int j = 0; j < 5; j++) begin
      step(1, 0, 0, 3);
      step(0, 0, 0, 3);
    end

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic c, a, v;
      c = ($urandom_range(0, 11) == 0) ? ~call : call;
      a = ($urandom_range(0, 29) == 0);
      v = ($urandom_range(0, 7) == 0) ? ~vib : vib;
      step(c, a, v, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
